// File: rtl/i2c_txn_sequencer.sv
// Transaction front end for i2c_master: turns one (address, direction, length)
// request into master command beats and routes the byte streams to and from it.
module i2c_txn_sequencer #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_address,
  input  logic             req_read,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [6:0]       cmd_address,
  output logic             cmd_start,
  output logic             cmd_read,
  output logic             cmd_write,
  output logic             cmd_write_multiple,
  output logic             cmd_stop,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       mst_tx_tdata,
  output logic             mst_tx_tvalid,
  input  logic             mst_tx_tready,
  output logic             mst_tx_tlast,
  input  logic [7:0]       mst_rx_tdata,
  input  logic             mst_rx_tvalid,
  output logic             mst_rx_tready,
  input  logic             mst_missed_ack,
  input  logic             mst_busy,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_CMD, S_WR_DATA, S_RD_CMD, S_RD_DATA, S_ABORT, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_addr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_err;
  logic             r_wait_seen;
  logic             w_last;
  logic             w_data_hs;
  logic             w_set_err;
  logic             w_accept;

  assign w_last = (r_cnt == (r_len - LEN_W'(1)));

  // Next state and all outputs decoded from the current state.
  always_comb begin
    w_next             = r_state;
    w_data_hs          = 1'b0;
    w_set_err          = 1'b0;
    w_accept           = 1'b0;
    req_ready          = 1'b0;
    busy               = (r_state != S_IDLE);
    done               = 1'b0;
    error              = 1'b0;
    cmd_address        = r_addr;
    cmd_valid          = 1'b0;
    cmd_start          = 1'b0;
    cmd_read           = 1'b0;
    cmd_write          = 1'b0;
    cmd_write_multiple = 1'b0;
    cmd_stop           = 1'b0;
    s_axis_tready      = 1'b0;
    mst_tx_tdata       = 8'h00;
    mst_tx_tvalid      = 1'b0;
    mst_tx_tlast       = 1'b0;
    mst_rx_tready      = 1'b0;
    m_axis_tdata       = 8'h00;
    m_axis_tvalid      = 1'b0;
    m_axis_tlast       = 1'b0;

    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (req_len == '0)  w_next = S_DONE;
          else if (req_read)  w_next = S_RD_CMD;
          else                w_next = S_WR_CMD;
        end
      end
      S_WR_CMD: begin
        cmd_valid          = 1'b1;
        cmd_write_multiple = 1'b1;
        cmd_start          = 1'b1;
        cmd_stop           = 1'b1;
        if (cmd_ready) w_next = S_WR_DATA;
      end
      S_WR_DATA: begin
        mst_tx_tdata  = s_axis_tdata;
        mst_tx_tvalid = s_axis_tvalid;
        s_axis_tready = mst_tx_tready;
        mst_tx_tlast  = w_last;
        w_data_hs     = s_axis_tvalid && mst_tx_tready;
        if (w_data_hs && w_last) w_next = S_WAIT_IDLE;
      end
      S_RD_CMD: begin
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_start = (r_cnt == '0);
        cmd_stop  = w_last;
        if (cmd_ready) w_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        m_axis_tdata  = mst_rx_tdata;
        m_axis_tvalid = mst_rx_tvalid;
        mst_rx_tready = m_axis_tready;
        m_axis_tlast  = w_last;
        w_data_hs     = mst_rx_tvalid && m_axis_tready;
        if (w_data_hs) w_next = w_last ? S_WAIT_IDLE : S_RD_CMD;
      end
      S_ABORT: begin
        cmd_valid = 1'b1;
        cmd_stop  = 1'b1;
        if (cmd_ready) w_next = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (r_wait_seen && !mst_busy) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        error  = r_err;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    // A missed ACK overrides any other transition, including a completed command handshake.
    if (mst_missed_ack && (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ABORT)) begin
      w_set_err = 1'b1;
      w_next    = S_ABORT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_wait_seen <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_wait_seen <= (r_state == S_WAIT_IDLE);
      if (w_accept) begin
        r_addr <= req_address;
        r_len  <= req_len;
        r_cnt  <= '0;
      end else if (w_data_hs) begin
        r_cnt  <= r_cnt + LEN_W'(1);
      end
      if (w_set_err || (w_accept && (req_len == '0))) r_err <= 1'b1;
      else if (r_state == S_DONE)                      r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Randomized bench for i2c_txn_sequencer: a behavioural i2c_master, upstream source
// and downstream sink, checked against per-transaction expected command/data lists.
module tb_i2c_txn_sequencer;
  localparam int unsigned LEN_W = 8;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_address;
  logic             req_read;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [7:0]       m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic [6:0]       cmd_address;
  logic             cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       mst_tx_tdata;
  logic             mst_tx_tvalid;
  logic             mst_tx_tready;
  logic             mst_tx_tlast;
  logic [7:0]       mst_rx_tdata;
  logic             mst_rx_tvalid;
  logic             mst_rx_tready;
  logic             mst_missed_ack;
  logic             mst_busy;
  logic             busy;
  logic             done;
  logic             error;

  i2c_txn_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
    .req_read(req_read), .req_len(req_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read), .cmd_write(cmd_write),
    .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .mst_tx_tdata(mst_tx_tdata), .mst_tx_tvalid(mst_tx_tvalid), .mst_tx_tready(mst_tx_tready),
    .mst_tx_tlast(mst_tx_tlast),
    .mst_rx_tdata(mst_rx_tdata), .mst_rx_tvalid(mst_rx_tvalid), .mst_rx_tready(mst_rx_tready),
    .mst_missed_ack(mst_missed_ack), .mst_busy(mst_busy),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Observed traffic and model state
  logic [11:0] obs_cmd[$];
  logic [8:0]  obs_tx[$];
  logic [8:0]  obs_rx[$];
  logic [7:0]  s_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  wr_preset[$];
  logic [7:0]  rd_preset[$];
  int          cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0;
  int          busy_cnt = 0, nack_cnt = 0, cmd_wait = 0;
  bit          acc_seen, any_cmd_valid, done_err, noslave, slow_cmd, toggle_m;
  bit          hold_pending;
  logic [11:0] held_cmd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] cur_cmd();
    return {cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop};
  endfunction

  function automatic bit coin();
    return ($urandom % 4) != 0;
  endfunction

  // One clock: sample at negedge, then update the environment just after posedge.
  task automatic step();
    bit s_hs, rx_hs, tx_hs, cmd_hs, cmd_rd, cmd_wm, acc_hs;
    logic [7:0] b;
    @(negedge clk);
    cyc++;
    acc_hs = req_valid && req_ready;
    if (acc_hs) begin acc_seen = 1'b1; acc_cyc = cyc; end
    cmd_hs = cmd_valid && cmd_ready;
    cmd_rd = cmd_read;
    cmd_wm = cmd_write_multiple;
    if (cmd_valid) any_cmd_valid = 1'b1;
    if (cmd_hs) obs_cmd.push_back(cur_cmd());
    if (hold_pending && cmd_valid) chk("cmd_hold", 32'(cur_cmd()), 32'(held_cmd));
    hold_pending = cmd_valid && !cmd_ready;
    held_cmd     = cur_cmd();
    tx_hs = mst_tx_tvalid && mst_tx_tready;
    if (tx_hs) obs_tx.push_back({mst_tx_tlast, mst_tx_tdata});
    s_hs  = s_axis_tvalid && s_axis_tready;
    rx_hs = mst_rx_tvalid && mst_rx_tready;
    if (m_axis_tvalid && m_axis_tready) obs_rx.push_back({m_axis_tlast, m_axis_tdata});
    if (done) begin done_cnt++; done_err = error; done_cyc = cyc; end

    @(posedge clk);
    #1;
    if (acc_hs) req_valid = 1'b0;
    if (s_hs && s_q.size() > 0) void'(s_q.pop_front());
    if (rx_hs && rx_q.size() > 0) void'(rx_q.pop_front());
    if (cmd_hs && cmd_rd) begin
      b = (rd_preset.size() > 0) ? rd_preset.pop_front() : 8'($urandom);
      rx_q.push_back(b);
      exp_rd.push_back(b);
    end
    if (cmd_hs && cmd_wm && noslave) nack_cnt = 3;
    if (cmd_hs || tx_hs || rx_hs) busy_cnt = 4;
    else if (busy_cnt > 0) busy_cnt--;
    mst_missed_ack = 1'b0;
    if (nack_cnt > 0) begin
      nack_cnt--;
      if (nack_cnt == 0) mst_missed_ack = 1'b1;
    end
    mst_busy = (busy_cnt != 0) || (nack_cnt != 0);
    if (cmd_hs || !cmd_valid) cmd_wait = 0;
    else cmd_wait++;
    cmd_ready     = slow_cmd ? (cmd_wait >= 5) : coin();
    mst_tx_tready = noslave ? 1'b0 : coin();
    mst_rx_tvalid = (rx_q.size() > 0) && coin();
    mst_rx_tdata  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    s_axis_tvalid = (s_q.size() > 0) && coin();
    s_axis_tdata  = (s_q.size() > 0) ? s_q[0] : 8'h00;
    m_axis_tready = toggle_m ? ~m_axis_tready : coin();
  endtask

  task automatic clear_model();
    obs_cmd.delete(); obs_tx.delete(); obs_rx.delete();
    s_q.delete(); rx_q.delete(); exp_rd.delete();
    done_cnt = 0; acc_seen = 1'b0; any_cmd_valid = 1'b0; hold_pending = 1'b0;
    busy_cnt = 0; nack_cnt = 0; cmd_wait = 0;
  endtask

  // Run one request end to end and compare against what the request should produce.
  task automatic run_txn(input logic [6:0] a, input bit rd, input int len, input bit nsl);
    logic [11:0] exp_cmd[$];
    logic [7:0]  wbytes[$];
    logic [7:0]  b;
    int          budget, n;
    clear_model();
    noslave = nsl;
    if (!rd) begin
      for (int i = 0; i < len; i++) begin
        b = (wr_preset.size() > 0) ? wr_preset.pop_front() : 8'($urandom);
        s_q.push_back(b);
        wbytes.push_back(b);
      end
    end
    if (len != 0) begin
      if (rd) begin
        for (int i = 0; i < len; i++)
          exp_cmd.push_back({a, (i == 0), 1'b1, 1'b0, 1'b0, (i == len - 1)});
      end else begin
        exp_cmd.push_back({a, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        if (nsl) exp_cmd.push_back({a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      end
    end
    s_axis_tvalid = (s_q.size() > 0);
    s_axis_tdata  = (s_q.size() > 0) ? s_q[0] : 8'h00;
    req_address = a;
    req_read    = rd;
    req_len     = LEN_W'(len);
    req_valid   = 1'b1;
    budget = 4000;
    while (done_cnt == 0 && budget > 0) begin step(); budget--; end
    if (budget == 0) chk("timeout", 32'd0, 32'd1);
    repeat (4) step();

    chk("accepted", 32'(acc_seen), 32'd1);
    chk("n_cmd", 32'(obs_cmd.size()), 32'(exp_cmd.size()));
    for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++)
      chk("cmd", 32'(obs_cmd[i]), 32'(exp_cmd[i]));
    if (rd) begin
      n = exp_rd.size();
      chk("rd_beats", 32'(obs_rx.size()), 32'(len));
      for (int i = 0; i < n && i < obs_rx.size(); i++)
        chk("rd_data", 32'(obs_rx[i]), 32'({(i == n - 1), exp_rd[i]}));
    end else begin
      n = nsl ? 0 : len;
      chk("wr_beats", 32'(obs_tx.size()), 32'(n));
      for (int i = 0; i < n && i < obs_tx.size(); i++)
        chk("wr_data", 32'(obs_tx[i]), 32'({(i == n - 1), wbytes[i]}));
    end
    chk("done_cnt", 32'(done_cnt), 32'd1);
    chk("error", 32'(done_err), 32'((len == 0) || nsl));
    if (len == 0) begin
      chk("zero_no_cmd", 32'(any_cmd_valid), 32'd0);
      chk("zero_latency", 32'((done_cyc - acc_cyc) <= 2), 32'd1);
    end
    if (nsl) chk("ups_left", 32'(s_q.size() >= 3), 32'd1);
    noslave = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, 32'({req_ready, busy, done, error, cmd_valid, cmd_start, cmd_read, cmd_write,
                  cmd_write_multiple, cmd_stop, s_axis_tready, m_axis_tvalid, m_axis_tlast,
                  mst_tx_tvalid, mst_tx_tlast, mst_rx_tready}), 32'h8000);
    chk({tag, "_data"}, 32'({cmd_address, m_axis_tdata, mst_tx_tdata}), 32'd0);
  endtask

  initial begin
    int budget;
    rst = 1'b0;
    req_valid = 1'b0; req_address = '0; req_read = 1'b0; req_len = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    cmd_ready = 1'b0; mst_tx_tready = 1'b0; mst_rx_tdata = '0; mst_rx_tvalid = 1'b0;
    mst_missed_ack = 1'b0; mst_busy = 1'b0;
    noslave = 1'b0; slow_cmd = 1'b0; toggle_m = 1'b0; hold_pending = 1'b0; held_cmd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    wr_preset = '{8'h11, 8'h22};
    run_txn(7'h22, 1'b0, 2, 1'b0);
    rd_preset = '{8'hA1, 8'hA2, 8'hA3};
    run_txn(7'h2a, 1'b1, 3, 1'b0);
    run_txn(7'h55, 1'b0, 4, 1'b1);
    run_txn(7'h10, 1'b0, 0, 1'b0);
    run_txn(7'h11, 1'b1, 0, 1'b0);

    slow_cmd = 1'b1; toggle_m = 1'b1;
    run_txn(7'h33, 1'b1, 8, 1'b0);
    run_txn(7'h34, 1'b0, 5, 1'b0);
    slow_cmd = 1'b0; toggle_m = 1'b0;

    run_txn(7'h40, 1'b1, 1, 1'b0);
    run_txn(7'h41, 1'b0, 1, 1'b0);
    run_txn(7'h42, 1'b0, 255, 1'b0);
    for (int t = 0; t < 10; t++)
      run_txn(7'($urandom_range(0, 127)), 1'($urandom), $urandom_range(1, 20), 1'b0);

    // Reset in the middle of a write after two data beats.
    clear_model();
    for (int i = 0; i < 4; i++) s_q.push_back(8'($urandom));
    req_address = 7'h22; req_read = 1'b0; req_len = LEN_W'(4); req_valid = 1'b1;
    budget = 500;
    while (obs_tx.size() < 2 && budget > 0) begin step(); budget--; end
    if (budget == 0) chk("mid_timeout", 32'd0, 32'd1);
    rst = 1'b0;
    clear_model();
    req_valid = 1'b0; s_axis_tvalid = 1'b0; mst_rx_tvalid = 1'b0;
    mst_missed_ack = 1'b0; mst_busy = 1'b0; cmd_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    run_txn(7'h22, 1'b0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
